// File: rtl/fp_alu_sequencer.sv
// Command sequencer for the float ALU: accepts one command, drives the ALU start/ready/valid
// handshake under a timeout guard, returns a response and accumulates sticky exception flags.
module fp_alu_sequencer #(
    parameter int N       = 32,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_op_a,
    input  logic [N-1:0] cmd_op_b,
    input  logic [2:0]   cmd_op_code,
    input  logic         cmd_mode_fp,
    input  logic         cmd_round_mode,
    output logic [N-1:0] alu_op_a,
    output logic [N-1:0] alu_op_b,
    output logic [2:0]   alu_op_code,
    output logic         alu_mode_fp,
    output logic         alu_round_mode,
    output logic         alu_start,
    output logic         alu_ready_in,
    input  logic         alu_ready_out,
    input  logic         alu_valid_out,
    input  logic [N-1:0] alu_result,
    input  logic [4:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [4:0]   rsp_flags,
    output logic [1:0]   rsp_status,
    output logic [4:0]   fflags,
    input  logic         fflags_clr,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0]    OP_DIV     = 3'd3;
    localparam logic [1:0]    ST_OK      = 2'b00;
    localparam logic [1:0]    ST_TIMEOUT = 2'b01;
    localparam logic [1:0]    ST_ILLEGAL = 2'b10;
    localparam logic [TW-1:0] CNT_LAST   = TW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic [TW-1:0] cnt;
    logic          accept, legal_op, done, timeout, active;

    assign accept   = (state == IDLE) && cmd_valid;
    assign legal_op = (cmd_op_code <= OP_DIV);
    assign active   = (state == ISSUE) || (state == WAIT);
    assign done     = (state == WAIT) && alu_valid_out;
    // Completion in the final allowed cycle beats the timeout.
    assign timeout  = active && (cnt == CNT_LAST) && !done;

    assign cmd_ready    = (state == IDLE);
    assign alu_start    = (state == ISSUE);
    assign alu_ready_in = (state == WAIT);
    assign rsp_valid    = (state == RESP);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (cmd_valid) state_nx = legal_op ? ISSUE : RESP;
            ISSUE: begin
                if (timeout)            state_nx = RESP;
                else if (alu_ready_out) state_nx = WAIT;
            end
            WAIT:  if (done || timeout) state_nx = RESP;
            RESP:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_mode_fp    <= 1'b0;
            alu_round_mode <= 1'b0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
            rsp_status     <= '0;
            cnt            <= '0;
        end else if (accept) begin
            alu_op_a       <= cmd_op_a;
            alu_op_b       <= cmd_op_b;
            alu_op_code    <= cmd_op_code;
            alu_mode_fp    <= cmd_mode_fp;
            alu_round_mode <= cmd_round_mode;
            cnt            <= '0;
            if (!legal_op) begin
                rsp_result <= '0;
                rsp_flags  <= '0;
                rsp_status <= ST_ILLEGAL;
            end
        end else if (active) begin
            cnt <= cnt + TW'(1);
            if (done) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                rsp_status <= ST_OK;
            end else if (timeout) begin
                rsp_result <= '0;
                rsp_flags  <= '0;
                rsp_status <= ST_TIMEOUT;
            end
        end
    end

    // A clear coinciding with a capture keeps only the newly captured flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fflags <= '0;
        else        fflags <= (fflags_clr ? 5'b0 : fflags) | (done ? alu_flags : 5'b0);
    end

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Self-checking bench for fp_alu_sequencer: a scripted ALU responder plus a
// transaction-level reference model of response, status, latency and fflags.
module tb_fp_alu_sequencer;
    localparam int N = 32;
    localparam int T = 8;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [N-1:0] cmd_op_a = '0, cmd_op_b = '0;
    logic [2:0]   cmd_op_code = '0;
    logic         cmd_mode_fp = 1'b0, cmd_round_mode = 1'b0;
    logic [N-1:0] alu_op_a, alu_op_b;
    logic [2:0]   alu_op_code;
    logic         alu_mode_fp, alu_round_mode, alu_start, alu_ready_in;
    logic         alu_ready_out, alu_valid_out;
    logic [N-1:0] alu_result;
    logic [4:0]   alu_flags;
    logic         rsp_valid, rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic [4:0]   rsp_flags, fflags;
    logic [1:0]   rsp_status;
    logic         fflags_clr, busy;

    fp_alu_sequencer #(.N(N), .TIMEOUT(T), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_op_code(cmd_op_code),
        .cmd_mode_fp(cmd_mode_fp), .cmd_round_mode(cmd_round_mode),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
        .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
        .alu_start(alu_start), .alu_ready_in(alu_ready_in), .alu_ready_out(alu_ready_out),
        .alu_valid_out(alu_valid_out), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_status(rsp_status), .fflags(fflags),
        .fflags_clr(fflags_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;

    // ALU responder controls
    int          ready_delay = 0, latency = 0;
    bit          never_valid = 1'b0, clr_on_cap = 1'b0;
    logic [31:0] alu_res_v = '0;
    logic [4:0]  alu_flg_v = '0;
    int          ph, rc;

    int          n_start, n_start_hi, op_bad;
    logic [68:0] exp_vec = '0;
    logic [4:0]  fflags_m = '0;

    initial begin
        ph = 0; rc = 0;
        alu_ready_out = 1'b0; alu_valid_out = 1'b0;
        alu_result = '0; alu_flags = '0; fflags_clr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0; alu_ready_out = 1'b0; alu_valid_out = 1'b0; fflags_clr = 1'b0;
            end else begin
                alu_ready_out = 1'b0;
                if (ph == 3) begin alu_valid_out = 1'b0; fflags_clr = 1'b0; ph = 0; end
                if (ph == 0 && alu_start) begin ph = 1; rc = ready_delay; end
                if (ph == 1) begin
                    if (!alu_start) ph = 0;
                    else if (rc == 0) begin alu_ready_out = 1'b1; ph = 2; rc = latency; end
                    else rc--;
                end else if (ph == 2) begin
                    if (!alu_ready_in) ph = 0;
                    else if (!never_valid) begin
                        if (rc == 0) begin
                            alu_valid_out = 1'b1; alu_result = alu_res_v;
                            alu_flags = alu_flg_v; fflags_clr = clr_on_cap; ph = 3;
                        end else rc--;
                    end
                end
            end
        end
    end

    initial begin
        n_start = 0; n_start_hi = 0; op_bad = 0;
        forever begin
            @(posedge clk);
            if (alu_start) n_start_hi++;
            if (alu_start && alu_ready_out) n_start++;
            if ((alu_start || alu_ready_in) &&
                {alu_op_code, alu_op_a, alu_op_b, alu_mode_fp, alu_round_mode} !== exp_vec)
                op_bad++;
        end
    end

    // Transaction-level expectation: ISSUE lasts d+1 cycles, WAIT lat+1, both within T.
    function automatic void model(input logic [2:0] op, input int d, lat, input bit never,
                                  input logic [31:0] res, input logic [4:0] flg,
                                  output logic [38:0] e_rsp, output int e_cyc, output int e_starts);
        if (op > 3'd3) begin
            e_rsp = {32'h0, 5'h0, 2'b10}; e_cyc = 1; e_starts = 0;
        end else if (!never && (d + lat + 2 <= T)) begin
            e_rsp = {res, flg, 2'b00}; e_cyc = d + lat + 3; e_starts = 1;
        end else begin
            e_rsp = {32'h0, 5'h0, 2'b01}; e_cyc = T + 1; e_starts = (d < T) ? 1 : 0;
        end
    endfunction

    task automatic run_txn(input logic [2:0] op, input logic [31:0] a, b, input logic mfp, rm,
                           input int d, lat, input bit never, input logic [31:0] res,
                           input logic [4:0] flg, input bit clr, output int cyc, output int rdy_hi);
        @(negedge clk);
        ready_delay = d; latency = lat; never_valid = never;
        alu_res_v = res; alu_flg_v = flg; clr_on_cap = clr;
        n_start = 0; n_start_hi = 0; op_bad = 0;
        exp_vec = {op, a, b, mfp, rm};
        cmd_valid = 1'b1; cmd_op_code = op; cmd_op_a = a; cmd_op_b = b;
        cmd_mode_fp = mfp; cmd_round_mode = rm;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op_a = $urandom; cmd_op_b = $urandom;
        cmd_op_code = 3'($urandom); cmd_mode_fp = ~mfp; cmd_round_mode = ~rm;
        cyc = 1; rdy_hi = 0;
        while (!rsp_valid && cyc < 100) begin
            if (cmd_ready) rdy_hi++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_rsp(input int hold);
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({cmd_ready, busy, alu_start, alu_ready_in, rsp_valid} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, busy, alu_start, alu_ready_in, rsp_valid});
        else pass_cnt++;
        total_cnt++;
        if ({alu_op_code, alu_op_a, alu_op_b, alu_mode_fp, alu_round_mode} !== 69'h0)
            $display("FAIL reset_alu_regs: got %h want 0", {alu_op_code, alu_op_a, alu_op_b, alu_mode_fp, alu_round_mode});
        else pass_cnt++;
        total_cnt++;
        if ({rsp_result, rsp_flags, rsp_status, fflags} !== 44'h0)
            $display("FAIL reset_rsp_regs: got %h want 0", {rsp_result, rsp_flags, rsp_status, fflags});
        else pass_cnt++;
        rst_n = 1'b1;
        fflags_m = '0;
    endtask

    task automatic test_add();
        int cyc, rdy_hi;
        run_txn(3'd0, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, 0, 3, 1'b0, 32'h40400000, 5'h0, 1'b0, cyc, rdy_hi);
        total_cnt++;
        if ({rsp_result, rsp_flags, rsp_status} !== {32'h40400000, 5'h0, 2'b00})
            $display("FAIL add_rsp: got %h/%h/%b want 40400000/00/00", rsp_result, rsp_flags, rsp_status);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 6) $display("FAIL add_latency: got %0d want 6", cyc); else pass_cnt++;
        total_cnt++;
        if (n_start !== 1 || n_start_hi !== 1)
            $display("FAIL add_start_pulse: got %0d accepted/%0d high want 1/1", n_start, n_start_hi);
        else pass_cnt++;
        total_cnt++;
        if (rdy_hi !== 0 || cmd_ready !== 1'b0)
            $display("FAIL add_cmd_ready_low: got %0d high cycles want 0", rdy_hi);
        else pass_cnt++;
        release_rsp(0);
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL add_cmd_ready_back: got %b want 1", cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_ready_stall();
        int cyc, rdy_hi;
        run_txn(3'd2, 32'h12345678, 32'h9abcdef0, 1'b0, 1'b1, 3, 1, 1'b0, 32'hCAFE0001, 5'h0, 1'b0, cyc, rdy_hi);
        total_cnt++;
        if (n_start_hi !== 4 || n_start !== 1)
            $display("FAIL stall_start: got %0d high/%0d accepted want 4/1", n_start_hi, n_start);
        else pass_cnt++;
        total_cnt++;
        if (op_bad !== 0) $display("FAIL stall_op_stable: got %0d unstable cycles want 0", op_bad);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 7 || rsp_result !== 32'hCAFE0001)
            $display("FAIL stall_rsp: got cyc %0d res %h want 7 CAFE0001", cyc, rsp_result);
        else pass_cnt++;
        release_rsp(0);
    endtask

    task automatic test_rsp_hold();
        int cyc, rdy_hi, bad;
        logic [39:0] snap;
        run_txn(3'd1, 32'h1, 32'h2, 1'b1, 1'b1, 1, 1, 1'b0, 32'h0BADF00D, 5'b00010, 1'b0, cyc, rdy_hi);
        fflags_m = fflags_m | 5'b00010;
        snap = {rsp_valid, rsp_result, rsp_flags, rsp_status};
        ready_delay = 0; latency = 0; alu_res_v = 32'h600D0001; alu_flg_v = 5'h0;
        cmd_valid = 1'b1; cmd_op_code = 3'd3; cmd_op_a = 32'hA5A5A5A5; cmd_op_b = 32'h5A5A5A5A;
        cmd_mode_fp = 1'b0; cmd_round_mode = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({rsp_valid, rsp_result, rsp_flags, rsp_status} !== snap || cmd_ready || alu_start) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL rsp_hold_stable: got %0d changed cycles want 0", bad); else pass_cnt++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_vec = {3'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0};
        total_cnt++;
        if ({cmd_ready, alu_start} !== 2'b10)
            $display("FAIL rsp_hold_no_bypass: got %b want 10", {cmd_ready, alu_start});
        else pass_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if ({cmd_ready, alu_start} !== 2'b01)
            $display("FAIL rsp_hold_next_accept: got %b want 01", {cmd_ready, alu_start});
        else pass_cnt++;
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin @(negedge clk); cyc++; end
        total_cnt++;
        if ({rsp_result, rsp_status} !== {32'h600D0001, 2'b00} || cyc !== 3)
            $display("FAIL rsp_hold_second: got %h/%b cyc %0d want 600D0001/00 cyc 3", rsp_result, rsp_status, cyc);
        else pass_cnt++;
        release_rsp(0);
    endtask

    task automatic test_timeout();
        int cyc, rdy_hi;
        run_txn(3'd3, 32'h3, 32'h4, 1'b1, 1'b0, 0, 0, 1'b1, 32'hFFFFFFFF, 5'h1F, 1'b0, cyc, rdy_hi);
        total_cnt++;
        if ({rsp_result, rsp_flags, rsp_status} !== {32'h0, 5'h0, 2'b01} || cyc !== T + 1)
            $display("FAIL timeout_rsp: got %h/%h/%b cyc %0d want 0/0/01 cyc %0d", rsp_result, rsp_flags, rsp_status, cyc, T + 1);
        else pass_cnt++;
        total_cnt++;
        if (fflags !== fflags_m) $display("FAIL timeout_fflags: got %b want %b", fflags, fflags_m); else pass_cnt++;
        release_rsp(1);
        run_txn(3'd0, 32'h5, 32'h6, 1'b1, 1'b0, 0, T - 2, 1'b0, 32'h1234ABCD, 5'b01000, 1'b0, cyc, rdy_hi);
        fflags_m = fflags_m | 5'b01000;
        total_cnt++;
        if ({rsp_result, rsp_status} !== {32'h1234ABCD, 2'b00} || cyc !== T + 1)
            $display("FAIL timeout_last_cycle_ok: got %h/%b cyc %0d want 1234ABCD/00 cyc %0d", rsp_result, rsp_status, cyc, T + 1);
        else pass_cnt++;
        release_rsp(0);
    endtask

    task automatic test_illegal();
        int cyc, rdy_hi;
        run_txn(3'b111, 32'h7, 32'h8, 1'b0, 1'b0, 0, 0, 1'b0, 32'h55555555, 5'h3, 1'b0, cyc, rdy_hi);
        total_cnt++;
        if ({rsp_result, rsp_flags, rsp_status} !== {32'h0, 5'h0, 2'b10} || cyc !== 1)
            $display("FAIL illegal_rsp: got %h/%h/%b cyc %0d want 0/0/10 cyc 1", rsp_result, rsp_flags, rsp_status, cyc);
        else pass_cnt++;
        total_cnt++;
        if (n_start_hi !== 0) $display("FAIL illegal_no_start: got %0d start cycles want 0", n_start_hi); else pass_cnt++;
        release_rsp(0);
    endtask

    task automatic test_fflags();
        int cyc, rdy_hi;
        rsp_ready = 1'b0;
        @(negedge clk);
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        fflags_m = '0;
        run_txn(3'd0, 32'h1, 32'h1, 1'b1, 1'b0, 0, 0, 1'b0, 32'h11, 5'b00001, 1'b0, cyc, rdy_hi);
        release_rsp(0);
        run_txn(3'd1, 32'h2, 32'h2, 1'b1, 1'b0, 1, 2, 1'b0, 32'h22, 5'b10000, 1'b0, cyc, rdy_hi);
        release_rsp(0);
        total_cnt++;
        if (fflags !== 5'b10001) $display("FAIL fflags_accum: got %b want 10001", fflags); else pass_cnt++;
        run_txn(3'd2, 32'h3, 32'h3, 1'b1, 1'b0, 0, 1, 1'b0, 32'h33, 5'b00100, 1'b1, cyc, rdy_hi);
        release_rsp(0);
        fflags_m = 5'b00100;
        total_cnt++;
        if (fflags !== 5'b00100) $display("FAIL fflags_clr_capture: got %b want 00100", fflags); else pass_cnt++;
    endtask

    task automatic test_random();
        int cyc, rdy_hi, d, lat, e_cyc, e_starts, hold;
        bit never;
        logic [2:0] op;
        logic [31:0] a, b, res;
        logic [4:0] flg;
        logic [38:0] e_rsp;
        for (int i = 0; i < 24; i++) begin
            op    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            a     = $urandom; b = $urandom; res = $urandom; flg = 5'($urandom);
            d     = $urandom_range(0, 4); lat = $urandom_range(0, 6);
            never = ($urandom_range(0, 4) == 0);
            hold  = $urandom_range(0, 3);
            model(op, d, lat, never, res, flg, e_rsp, e_cyc, e_starts);
            run_txn(op, a, b, 1'($urandom), 1'($urandom), d, lat, never, res, flg, 1'b0, cyc, rdy_hi);
            if (e_rsp[1:0] == 2'b00) fflags_m = fflags_m | flg;
            total_cnt++;
            if ({rsp_result, rsp_flags, rsp_status} !== e_rsp)
                $display("FAIL rand_rsp[%0d]: got %h want %h", i, {rsp_result, rsp_flags, rsp_status}, e_rsp);
            else pass_cnt++;
            total_cnt++;
            if (cyc !== e_cyc || n_start !== e_starts || op_bad !== 0)
                $display("FAIL rand_timing[%0d]: got cyc %0d starts %0d bad %0d want cyc %0d starts %0d bad 0",
                         i, cyc, n_start, op_bad, e_cyc, e_starts);
            else pass_cnt++;
            release_rsp(hold);
            total_cnt++;
            if (fflags !== fflags_m) $display("FAIL rand_fflags[%0d]: got %b want %b", i, fflags, fflags_m);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_wait();
        int guard, seen;
        @(negedge clk);
        ready_delay = 0; latency = 0; never_valid = 1'b1;
        exp_vec = {3'd0, 32'hDEAD0000, 32'h0000BEEF, 1'b1, 1'b1};
        cmd_valid = 1'b1; cmd_op_code = 3'd0; cmd_op_a = 32'hDEAD0000; cmd_op_b = 32'h0000BEEF;
        cmd_mode_fp = 1'b1; cmd_round_mode = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!alu_ready_in && guard < 10) begin @(negedge clk); guard++; end
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({cmd_ready, busy, alu_start, alu_ready_in, rsp_valid} !== 5'b10000 || guard >= 10)
            $display("FAIL reset_mid_ctrl: got %b want 10000", {cmd_ready, busy, alu_start, alu_ready_in, rsp_valid});
        else pass_cnt++;
        total_cnt++;
        if ({alu_op_code, alu_op_a, alu_op_b, alu_mode_fp, alu_round_mode, rsp_result, rsp_flags, rsp_status, fflags} !== 113'h0)
            $display("FAIL reset_mid_regs: got nonzero %h want 0", {alu_op_a, rsp_result, fflags});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        fflags_m = '0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (rsp_valid || busy) seen++; end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_mid_no_rsp: got %0d busy cycles want 0", seen); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ready_stall();
        test_rsp_hold();
        test_timeout();
        test_illegal();
        test_fflags();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
